block_code_frame_ctrl: RTL and testbench

Frame scheduler in front of the block-code decoder (top_block_code).
- Queues per-frame code-length commands.
- Holds the decoder's code_length stable for a whole frame.
- Gates the upstream AXI-Stream symbol stream into the decoder in frames of exactly NUM_SYMBOLS beats, generating the decoder's tlast itself.
- Waits for the decoder's output tlast before starting the next frame.
- Repairs malformed upstream frames by zero-padding short frames and flushing long ones, and flags each repair.

---
 rtl/block_code_pkg.sv | 29 ++
 rtl/block_code_cfg_fifo.sv | 58 +++++
 rtl/block_code_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_block_code_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_code_pkg.sv
// Shared types and constants for the block-code decoder front end.
// Contents:
//   frame_state_t  frame scheduler state encoding
//   CODE_LEN_W     width of a code-length command
//   DEF_*          default stream/frame geometry
//   code_len_ok()  legality test for a code-length command
package block_code_pkg;

  localparam int CODE_LEN_W      = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_SYMBOLS = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    PAD,
    FLUSH,
    WAIT_DONE
  } frame_state_t;

  // A command is usable when it is non-zero and no larger than the
  // decoder's largest supported code length.
  function automatic logic code_len_ok(input logic [CODE_LEN_W-1:0] len,
                                       input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/block_code_cfg_fifo.sv
// Synchronous command FIFO holding per-frame code-length commands.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push          write request (ignored while full)
//   push_data     command to write
//   pop           read request (ignored while empty)
//   pop_data      head-of-queue command (valid while !empty)
//   full, empty   occupancy flags
// A push and a pop in the same cycle are both honoured.
module block_code_cfg_fifo
  import block_code_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/block_code_frame_ctrl.sv
// Frame scheduler in front of the block-code decoder.
// Queues code-length commands, holds the decoder's code length for a whole
// frame, gates the upstream symbol stream into frames of exactly
// NUM_SYMBOLS beats (generating the decoder tlast), waits for the decoder
// to finish each frame, and repairs malformed upstream frames.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_tdata/tvalid/tready   code-length command stream
//   s_axis_*                  upstream symbol stream
//   dec_tdata/tvalid/tready/tlast  symbol stream into the decoder
//   dec_code_length           code length presented to the decoder
//   dec_done_tvalid/tlast     decoder output handshake (end of frame)
//   busy                      scheduler is not idle
//   frame_err                 1-cycle pulse: tlast mismatch or timeout
//   cfg_err                   1-cycle pulse: command rejected
//   frames_done               completed-frame counter (wraps)
module block_code_frame_ctrl
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_SYMBOLS    = DEF_NUM_SYMBOLS,
  parameter int CFG_DEPTH      = 4,
  parameter int MAX_CODE_LEN   = 31,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_LEN_W-1:0] cfg_tdata,
  input  logic                  cfg_tvalid,
  output logic                  cfg_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] dec_tdata,
  output logic                  dec_tvalid,
  input  logic                  dec_tready,
  output logic                  dec_tlast,
  output logic [CODE_LEN_W-1:0] dec_code_length,
  input  logic                  dec_done_tvalid,
  input  logic                  dec_done_tlast,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  cfg_err,
  output logic [15:0]           frames_done
);

  // A one-symbol frame still needs a 1-bit counter.
  localparam int CNT_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SYMBOLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  frame_state_t          state;
  frame_state_t          state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [TMR_W-1:0]      tmr;
  logic                  is_last;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CODE_LEN_W-1:0] fifo_head;
  logic                  load_len;
  logic                  done_evt;
  logic                  frame_err_nxt;
  logic                  cfg_err_nxt;
  logic                  frame_err_p1;
  logic                  cfg_err_p1;
  logic [CODE_LEN_W-1:0] code_len_q;
  logic [15:0]           frames_q;

  block_code_cfg_fifo #(
    .DEPTH (CFG_DEPTH),
    .WIDTH (CODE_LEN_W)
  ) u_cfg_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cfg_tvalid),
    .push_data (cfg_tdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign is_last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    fifo_pop      = 1'b0;
    load_len      = 1'b0;
    done_evt      = 1'b0;
    frame_err_nxt = 1'b0;
    cfg_err_nxt   = 1'b0;
    s_axis_tready = 1'b0;
    dec_tvalid    = 1'b0;
    dec_tdata     = '0;
    dec_tlast     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (code_len_ok(fifo_head, MAX_CODE_LEN)) begin
            load_len  = 1'b1;
            state_nxt = LOAD;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      // One idle cycle lets the decoder absorb the new code length.
      LOAD: state_nxt = STREAM;
      STREAM: begin
        dec_tdata     = s_axis_tdata;
        dec_tvalid    = s_axis_tvalid;
        s_axis_tready = dec_tready;
        dec_tlast     = is_last;
        if (s_axis_tvalid && dec_tready) begin
          cnt_nxt = is_last ? '0 : cnt + CNT_ONE;
          if (is_last) begin
            if (s_axis_tlast) begin
              state_nxt = WAIT_DONE;
            end else begin
              // Upstream frame is too long: drop the rest of it.
              frame_err_nxt = 1'b1;
              state_nxt     = FLUSH;
            end
          end else if (s_axis_tlast) begin
            // Upstream frame is too short: fill the rest with zeros.
            frame_err_nxt = 1'b1;
            state_nxt     = PAD;
          end
        end
      end
      PAD: begin
        dec_tvalid = 1'b1;
        dec_tlast  = is_last;
        if (dec_tready) begin
          cnt_nxt = is_last ? '0 : cnt + CNT_ONE;
          if (is_last) state_nxt = WAIT_DONE;
        end
      end
      FLUSH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dec_done_tvalid && dec_done_tlast) begin
          done_evt  = 1'b1;
          state_nxt = IDLE;
        end else if (tmr == TMR_LAST) begin
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tmr          <= '0;
      code_len_q   <= '0;
      frames_q     <= '0;
      frame_err_p1 <= 1'b0;
      cfg_err_p1   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      // Timer runs only while staying in WAIT_DONE; cleared everywhere else.
      tmr          <= (state == WAIT_DONE && state_nxt == WAIT_DONE) ?
                      tmr + TMR_ONE : '0;
      if (load_len) code_len_q <= fifo_head;
      if (done_evt) frames_q   <= frames_q + 16'd1;
      frame_err_p1 <= frame_err_nxt;
      cfg_err_p1   <= cfg_err_nxt;
    end
  end

  assign cfg_tready      = ~fifo_full;
  assign dec_code_length = code_len_q;
  assign busy            = (state != IDLE);
  assign frame_err       = frame_err_p1;
  assign cfg_err         = cfg_err_p1;
  assign frames_done     = frames_q;

endmodule

// File: tb/tb_block_code_frame_ctrl.sv
module tb_block_code_frame_ctrl;

  localparam int DW  = 8;
  localparam int NS  = 20;
  localparam int TMO = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    cfg_tdata = '0;
  logic          cfg_tvalid = 1'b0;
  logic          cfg_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] dec_tdata;
  logic          dec_tvalid;
  logic          dec_tready = 1'b0;
  logic          dec_tlast;
  logic [7:0]    dec_code_length;
  logic          dec_done_tvalid = 1'b0;
  logic          dec_done_tlast = 1'b0;
  logic          busy;
  logic          frame_err;
  logic          cfg_err;
  logic [15:0]   frames_done;

  int vectors = 0;
  int miscompares = 0;
  int exp_frames = 0;
  int cfg_errs = 0;

  block_code_frame_ctrl #(
    .DATA_WIDTH     (DW),
    .NUM_SYMBOLS    (NS),
    .CFG_DEPTH      (4),
    .MAX_CODE_LEN   (31),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_tdata       (cfg_tdata),
    .cfg_tvalid      (cfg_tvalid),
    .cfg_tready      (cfg_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .dec_tdata       (dec_tdata),
    .dec_tvalid      (dec_tvalid),
    .dec_tready      (dec_tready),
    .dec_tlast       (dec_tlast),
    .dec_code_length (dec_code_length),
    .dec_done_tvalid (dec_done_tvalid),
    .dec_done_tlast  (dec_done_tlast),
    .busy            (busy),
    .frame_err       (frame_err),
    .cfg_err         (cfg_err),
    .frames_done     (frames_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one command until accepted or the bound expires.
  task automatic push_cfg(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    cfg_tdata  = v;
    cfg_tvalid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (cfg_err) cfg_errs++;
      if (cfg_tready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cfg_tvalid = 1'b0;
  endtask

  // Runs one frame: upstream sends n random beats (tlast on the n-th), the
  // decoder model optionally answers with done. Expected decoder stream is
  // the first NS upstream beats, zero-filled to NS beats.
  task automatic run_frame(input int n, input bit reply, input bit bp, input logic [7:0] exp_len);
    logic [DW-1:0] src[$];
    logic [DW-1:0] got[$];
    int tlast_pos[$];
    int idx = 0, errs = 0, cyc = 0, wait_cyc = 0, rdy_viol = 0, len_viol = 0, bad = 0;
    int delay;
    bit started = 0, fin = 0, seen_last = 0, pend = 0;
    logic [DW-1:0] expv;
    for (int i = 0; i < n; i++) src.push_back(DW'($urandom));
    delay = $urandom_range(0, 5);
    while (!fin && cyc < 4000) begin
      if (!pend) pend = (idx < n) && ($urandom_range(0, 3) != 0);
      s_axis_tvalid = pend;
      s_axis_tdata  = (idx < n) ? src[idx] : '0;
      s_axis_tlast  = (idx == n - 1);
      dec_tready    = bp ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (seen_last && reply) begin
        if (delay == 0) begin
          dec_done_tvalid = 1'b1;
          dec_done_tlast  = 1'b1;
        end else delay--;
      end
      @(negedge clk);
      if (cfg_err) cfg_errs++;
      if (frame_err) errs++;
      if (busy) started = 1'b1;
      if (busy && dec_code_length !== exp_len) len_viol++;
      if (started && busy && idx == n && s_axis_tready) rdy_viol++;
      if (seen_last && busy) wait_cyc++;
      if (s_axis_tvalid && s_axis_tready) begin
        idx++;
        pend = 1'b0;
      end
      if (dec_tvalid && dec_tready) begin
        got.push_back(dec_tdata);
        if (dec_tlast) begin
          tlast_pos.push_back(got.size());
          seen_last = 1'b1;
        end
      end
      if (started && !busy) fin = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    dec_done_tvalid = 1'b0;
    dec_done_tlast  = 1'b0;
    for (int i = 0; i < NS && i < got.size(); i++) begin
      expv = (i < n) ? src[i] : '0;
      if (got[i] !== expv) bad++;
    end
    check("frame_completed", 32'(fin), 1);
    check("dec_beat_count", got.size(), NS);
    check("dec_beat_data_errors", bad, 0);
    check("dec_tlast_count", tlast_pos.size(), 1);
    check("dec_tlast_position", (tlast_pos.size() > 0) ? tlast_pos[0] : 0, NS);
    check("upstream_beats_taken", idx, n);
    check("frame_err_pulses", errs, int'(n != NS) + int'(!reply));
    check("code_length_hold_errors", len_viol, 0);
    check("tready_after_upstream_tlast", rdy_viol, 0);
    if (reply) exp_frames++;
    check("frames_done", frames_done, exp_frames);
    if (!reply) check("timeout_wait_cycles", wait_cyc, TMO);
  endtask

  initial begin
    bit ok;
    int base;
    int hs;
    int lbusy;
    int lerr;
    logic [7:0] len;

    // Reset and reset-state outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_tready", cfg_tready, 1);
    check("rst_busy", busy, 0);
    check("rst_dec_tvalid", dec_tvalid, 0);
    check("rst_dec_tlast", dec_tlast, 0);
    check("rst_dec_tdata", dec_tdata, 0);
    check("rst_s_axis_tready", s_axis_tready, 0);
    check("rst_code_length", dec_code_length, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_errs", {frame_err, cfg_err}, 0);
    @(posedge clk); #1;

    // Nominal, short and long frames.
    push_cfg(8'd13, ok); check("push_13", 32'(ok), 1);
    run_frame(20, 1'b1, 1'b0, 8'd13);
    push_cfg(8'd5, ok);
    run_frame(12, 1'b1, 1'b0, 8'd5);
    push_cfg(8'd5, ok);
    run_frame(25, 1'b1, 1'b0, 8'd5);

    // Rejected commands interleaved with queued good ones.
    base = cfg_errs;
    push_cfg(8'd0, ok);
    push_cfg(8'd40, ok);
    push_cfg(8'd13, ok);
    push_cfg(8'd7, ok);
    run_frame(20, 1'b1, 1'b0, 8'd13);
    run_frame(20, 1'b1, 1'b0, 8'd7);
    check("cfg_err_pulses", cfg_errs - base, 2);

    // Random frame lengths and code lengths.
    for (int k = 0; k < 4; k++) begin
      len = 8'($urandom_range(1, 31));
      push_cfg(len, ok);
      run_frame($urandom_range(1, 30), 1'b1, 1'b0, len);
    end

    // Backpressure, then a frame the decoder never finishes.
    len = 8'($urandom_range(1, 31));
    push_cfg(len, ok);
    run_frame($urandom_range(1, 30), 1'b1, 1'b1, len);
    push_cfg(8'd9, ok);
    run_frame(20, 1'b0, 1'b1, 8'd9);

    // Fill the FIFO while a frame is stalled, then reset at beat 7.
    push_cfg(8'd9, ok);
    for (int i = 0; i < 4; i++) push_cfg(8'd8, ok);
    @(negedge clk);
    check("fifo_full_tready", cfg_tready, 0);
    @(posedge clk); #1;
    push_cfg(8'd8, ok);
    check("fifo_full_blocks_push", 32'(ok), 0);
    hs = 0;
    dec_tready = 1'b1;
    for (int i = 0; i < 60 && hs < 7; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(i + 1);
      s_axis_tlast  = 1'b0;
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) hs++;
      @(posedge clk); #1;
    end
    check("beats_before_reset", hs, 7);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dec_tvalid", dec_tvalid, 0);
    check("mid_rst_cfg_tready", cfg_tready, 1);
    check("mid_rst_frames_done", frames_done, 0);
    lbusy = 0;
    lerr  = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy) lbusy++;
      if (frame_err) lerr++;
    end
    check("post_rst_fifo_empty", lbusy, 0);
    check("post_rst_no_frame_err", lerr, 0);
    @(posedge clk); #1;
    push_cfg(8'd13, ok);
    run_frame(20, 1'b1, 1'b0, 8'd13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
